// File: rtl/snitch_hwloop_pkg.sv
// Shared constants and types for the Snitch hardware-loop setup controller.
// Optional feature macro: SNITCH_HWLOOP_CHECK_EN (zero-length loop rejection).
package snitch_hwloop_pkg;

    localparam logic [6:0] HWLOOP_OPCODE = 7'b1111011;
    localparam int unsigned SETTLE_CNT_W = 3;

    typedef enum logic [2:0] {
        F3_STARTI = 3'b000,
        F3_ENDI   = 3'b001,
        F3_COUNT  = 3'b010,
        F3_COUNTI = 3'b011,
        F3_SETUP  = 3'b100,
        F3_SETUPI = 3'b101
    } hwloop_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_SETTLE = 2'd2
    } hwloop_state_e;

    // Value loaded into the settle down-counter on leaving WRITE; SETTLE
    // exits when the counter reads zero, so N cycles need a load of N-1.
    function automatic logic [SETTLE_CNT_W-1:0] settle_load(input int unsigned cycles);
        return (cycles == 0) ? '0 : SETTLE_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/snitch_hwloop_decode.sv
// Combinational decode of hwloop setup instructions and loop address compute.
// With SNITCH_HWLOOP_CHECK_EN defined, zero-length loop encodings are illegal.
module snitch_hwloop_decode
    import snitch_hwloop_pkg::*;
(
    input  logic [31:0] inst_data,
    input  logic [31:0] inst_pc,
    input  logic [31:0] rs1_data,
    output logic        legal,
    output logic        regid,
    output logic        we_start,
    output logic        we_end,
    output logic        we_count,
    output logic [31:0] start_addr,
    output logic [31:0] end_addr,
    output logic [31:0] cnt_data
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  uimm5;
    logic [11:0] uimm12;
    logic [31:0] pc_plus4;
    logic [31:0] pc_rel12;
    logic [31:0] pc_rel5;
    logic        unused_rd_bits;

    assign opcode = inst_data[6:0];
    assign regid  = inst_data[7];
    assign funct3 = inst_data[14:12];
    assign uimm5  = inst_data[19:15];
    assign uimm12 = inst_data[31:20];
    assign unused_rd_bits = ^inst_data[11:8];

    // Offsets are halfword-scaled and unsigned; adds wrap modulo 2^32.
    assign pc_plus4 = inst_pc + 32'd4;
    assign pc_rel12 = inst_pc + {19'd0, uimm12, 1'b0};
    assign pc_rel5  = inst_pc + {26'd0, uimm5, 1'b0};

`ifdef SNITCH_HWLOOP_CHECK_EN
    logic zero_len;
    assign zero_len = (((funct3 == F3_ENDI) || (funct3 == F3_SETUP)) && (uimm12 == 12'd0))
                   || ((funct3 == F3_SETUPI) && (uimm5 == 5'd0));
`endif

    // NOTE: every output gets a default before the case, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        legal      = 1'b0;
        we_start   = 1'b0;
        we_end     = 1'b0;
        we_count   = 1'b0;
        start_addr = pc_plus4;
        end_addr   = pc_rel12;
        cnt_data   = rs1_data;

        if (opcode == HWLOOP_OPCODE) begin
            case (funct3)
                F3_STARTI: begin
                    legal      = 1'b1;
                    we_start   = 1'b1;
                    start_addr = pc_rel12;
                end
                F3_ENDI: begin
                    legal  = 1'b1;
                    we_end = 1'b1;
                end
                F3_COUNT: begin
                    legal    = 1'b1;
                    we_count = 1'b1;
                end
                F3_COUNTI: begin
                    legal    = 1'b1;
                    we_count = 1'b1;
                    cnt_data = {20'd0, uimm12};
                end
                F3_SETUP: begin
                    legal    = 1'b1;
                    we_start = 1'b1;
                    we_end   = 1'b1;
                    we_count = 1'b1;
                end
                F3_SETUPI: begin
                    legal    = 1'b1;
                    we_start = 1'b1;
                    we_end   = 1'b1;
                    we_count = 1'b1;
                    end_addr = pc_rel5;
                    cnt_data = {20'd0, uimm12};
                end
                default: ;
            endcase
        end

`ifdef SNITCH_HWLOOP_CHECK_EN
        if (zero_len) begin
            legal    = 1'b0;
            we_start = 1'b0;
            we_end   = 1'b0;
            we_count = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/snitch_hwloop_ctrl.sv
// Hardware-loop setup controller: accepts one lp.* instruction, writes the loop
// registers for one cycle, then settles. Optional macro: SNITCH_HWLOOP_CHECK_EN.
module snitch_hwloop_ctrl
    import snitch_hwloop_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inst_valid_i,
    output logic        inst_ready_o,
    input  logic [31:0] inst_data_i,
    input  logic [31:0] inst_pc_i,
    input  logic [31:0] rs1_data_i,
    output logic        hwloop_regid_o,
    output logic [31:0] hwloop_start_address_o,
    output logic [31:0] hwloop_end_address_o,
    output logic [31:0] hwloop_cnt_data_o,
    output logic        hwloop_we_start_register_o,
    output logic        hwloop_we_end_register_o,
    output logic        hwloop_we_count_register_o,
    output logic        busy_o,
    output logic        illegal_o
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);

    hwloop_state_e state_q, state_d;
    logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;

    logic        accept;
    logic        dec_legal;
    logic        dec_regid;
    logic        dec_we_start;
    logic        dec_we_end;
    logic        dec_we_count;
    logic [31:0] dec_start;
    logic [31:0] dec_end;
    logic [31:0] dec_cnt;

    snitch_hwloop_decode u_decode (
        .inst_data  (inst_data_i),
        .inst_pc    (inst_pc_i),
        .rs1_data   (rs1_data_i),
        .legal      (dec_legal),
        .regid      (dec_regid),
        .we_start   (dec_we_start),
        .we_end     (dec_we_end),
        .we_count   (dec_we_count),
        .start_addr (dec_start),
        .end_addr   (dec_end),
        .cnt_data   (dec_cnt)
    );

    assign inst_ready_o = (state_q == ST_IDLE);
    assign busy_o       = ~inst_ready_o;
    assign accept       = inst_valid_i & inst_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && dec_legal) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                settle_cnt_d = '0;
            end
        endcase
    end

    // Enables and illegal_o are one-cycle pulses; the data fields keep their
    // last written value so downstream sees stable loop bounds between writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hwloop_we_start_register_o <= 1'b0;
            hwloop_we_end_register_o   <= 1'b0;
            hwloop_we_count_register_o <= 1'b0;
            illegal_o                  <= 1'b0;
            hwloop_regid_o             <= 1'b0;
            hwloop_start_address_o     <= '0;
            hwloop_end_address_o       <= '0;
            hwloop_cnt_data_o          <= '0;
        end else begin
            hwloop_we_start_register_o <= accept & dec_legal & dec_we_start;
            hwloop_we_end_register_o   <= accept & dec_legal & dec_we_end;
            hwloop_we_count_register_o <= accept & dec_legal & dec_we_count;
            illegal_o                  <= accept & ~dec_legal;
            if (accept && dec_legal) begin
                hwloop_regid_o <= dec_regid;
                if (dec_we_start) hwloop_start_address_o <= dec_start;
                if (dec_we_end)   hwloop_end_address_o   <= dec_end;
                if (dec_we_count) hwloop_cnt_data_o      <= dec_cnt;
            end
        end
    end

endmodule

// File: tb/tb_snitch_hwloop_ctrl.sv
// Directed self-checking bench for snitch_hwloop_ctrl (default SETTLE_CYCLES=2).
// Zero-length expectations follow SNITCH_HWLOOP_CHECK_EN when it is defined.
module tb_snitch_hwloop_ctrl;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] rs1_data;
    logic        regid;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
    logic [31:0] cnt_data;
    logic        we_start;
    logic        we_end;
    logic        we_count;
    logic        busy;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    snitch_hwloop_ctrl dut (
        .clk_i                      (clk),
        .rst_ni                     (rst_n),
        .inst_valid_i               (inst_valid),
        .inst_ready_o               (inst_ready),
        .inst_data_i                (inst_data),
        .inst_pc_i                  (inst_pc),
        .rs1_data_i                 (rs1_data),
        .hwloop_regid_o             (regid),
        .hwloop_start_address_o     (start_addr),
        .hwloop_end_address_o       (end_addr),
        .hwloop_cnt_data_o          (cnt_data),
        .hwloop_we_start_register_o (we_start),
        .hwloop_we_end_register_o   (we_end),
        .hwloop_we_count_register_o (we_count),
        .busy_o                     (busy),
        .illegal_o                  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [2:0] f3, input logic rid,
                                        input logic [11:0] u12, input logic [4:0] u5,
                                        input logic [6:0] opc);
        return {u12, u5, f3, 4'b0000, rid, opc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (inst_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (inst_ready !== 1'b1) begin
            bad++;
            $display("FAIL wait_ready: ready=%b after %0d cycles, need 1", inst_ready, n);
        end
    endtask

    // Presents one instruction, lets it be accepted, and returns in cycle t+1.
    task automatic offer(input logic [31:0] data, input logic [31:0] pc, input logic [31:0] rs1);
        inst_data  = data;
        inst_pc    = pc;
        rs1_data   = rs1;
        inst_valid = 1'b1;
        wait_ready();
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inst_valid = 1'b0; inst_data = '0; inst_pc = '0; rs1_data = '0;
        #12;
        total++;
        if ({we_start, we_end, we_count, illegal, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: we/ill/busy=%b need 00000", {we_start, we_end, we_count, illegal, busy});
        end
        total++;
        if ({regid, start_addr, end_addr, cnt_data} !== 97'd0) begin
            bad++;
            $display("FAIL reset_data: regid=%b s=%h e=%h c=%h need all 0", regid, start_addr, end_addr, cnt_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (inst_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: ready=%b need 1", inst_ready);
        end
    endtask

    task automatic test_setup();
        offer(enc(3'b100, 1'b1, 12'h010, 5'd0, 7'b1111011), 32'h0000_1000, 32'd5);
        total++;
        if ({we_start, we_end, we_count, regid} !== 4'b1111) begin
            bad++;
            $display("FAIL setup_we: we/regid=%b need 1111", {we_start, we_end, we_count, regid});
        end
        total++;
        if (start_addr !== 32'h0000_1004 || end_addr !== 32'h0000_1020 || cnt_data !== 32'd5) begin
            bad++;
            $display("FAIL setup_data: s=%h e=%h c=%h need 00001004 00001020 00000005",
                     start_addr, end_addr, cnt_data);
        end
        total++;
        if (inst_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL setup_busy: ready=%b busy=%b need 0 1", inst_ready, busy);
        end
        tick();
        total++;
        if ({we_start, we_end, we_count} !== 3'b000 || end_addr !== 32'h0000_1020) begin
            bad++;
            $display("FAIL setup_after: we=%b e=%h need 000 00001020", {we_start, we_end, we_count}, end_addr);
        end
    endtask

    task automatic test_back_to_back();
        int first  = -1;
        int second = -1;
        int lows   = 0;
        wait_ready();
        inst_data  = enc(3'b011, 1'b0, 12'h007, 5'd0, 7'b1111011);
        inst_pc    = 32'h0000_3000;
        rs1_data   = 32'd0;
        inst_valid = 1'b1;
        for (int i = 0; i < 12 && second < 0; i++) begin
            if (inst_ready === 1'b1) begin
                if (first < 0) first = i;
                else second = i;
            end else if (first >= 0) begin
                lows++;
            end
            tick();
        end
        inst_valid = 1'b0;
        total++;
        if (first !== 0 || second !== 4) begin
            bad++;
            $display("FAIL b2b_spacing: accepts at %0d,%0d need 0,4", first, second);
        end
        total++;
        if (lows !== 3) begin
            bad++;
            $display("FAIL b2b_ready_low: low cycles=%0d need 3", lows);
        end
        total++;
        if ({we_start, we_end, we_count} !== 3'b001 || cnt_data !== 32'h0000_0007) begin
            bad++;
            $display("FAIL b2b_second_write: we=%b c=%h need 001 00000007", {we_start, we_end, we_count}, cnt_data);
        end
    endtask

    task automatic test_counti();
        offer(enc(3'b011, 1'b0, 12'hFFF, 5'd0, 7'b1111011), 32'h0000_4000, 32'hDEAD_BEEF);
        total++;
        if ({we_start, we_end, we_count, regid} !== 4'b0010) begin
            bad++;
            $display("FAIL counti_we: we/regid=%b need 0010", {we_start, we_end, we_count, regid});
        end
        total++;
        if (cnt_data !== 32'h0000_0FFF) begin
            bad++;
            $display("FAIL counti_data: c=%h need 00000fff", cnt_data);
        end
    endtask

    task automatic test_endi_wrap();
        offer(enc(3'b001, 1'b1, 12'h010, 5'd0, 7'b1111011), 32'hFFFF_FFF0, 32'd0);
        total++;
        if ({we_start, we_end, we_count} !== 3'b010 || end_addr !== 32'h0000_0010) begin
            bad++;
            $display("FAIL endi_wrap: we=%b e=%h need 010 00000010", {we_start, we_end, we_count}, end_addr);
        end
    endtask

    task automatic test_illegal();
        offer(enc(3'b111, 1'b0, 12'h123, 5'd1, 7'b1111011), 32'h0000_5000, 32'd9);
        total++;
        if (illegal !== 1'b1 || {we_start, we_end, we_count} !== 3'b000) begin
            bad++;
            $display("FAIL illegal_f3: ill=%b we=%b need 1 000", illegal, {we_start, we_end, we_count});
        end
        total++;
        if (inst_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL illegal_ready: ready=%b busy=%b need 1 0", inst_ready, busy);
        end
        tick();
        total++;
        if (illegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_pulse: ill=%b need 0", illegal);
        end
        offer(enc(3'b100, 1'b0, 12'h010, 5'd0, 7'b0110011), 32'h0000_5000, 32'd9);
        total++;
        if (illegal !== 1'b1 || {we_start, we_end, we_count} !== 3'b000) begin
            bad++;
            $display("FAIL illegal_opcode: ill=%b we=%b need 1 000", illegal, {we_start, we_end, we_count});
        end
        tick();
    endtask

    task automatic test_zero_len();
        offer(enc(3'b101, 1'b0, 12'h003, 5'd0, 7'b1111011), 32'h0000_2000, 32'd0);
`ifdef SNITCH_HWLOOP_CHECK_EN
        total++;
        if (illegal !== 1'b1 || {we_start, we_end, we_count} !== 3'b000) begin
            bad++;
            $display("FAIL zero_len_check: ill=%b we=%b need 1 000", illegal, {we_start, we_end, we_count});
        end
`else
        total++;
        if (illegal !== 1'b0 || {we_start, we_end, we_count} !== 3'b111) begin
            bad++;
            $display("FAIL zero_len_we: ill=%b we=%b need 0 111", illegal, {we_start, we_end, we_count});
        end
        total++;
        if (start_addr !== 32'h0000_2004 || end_addr !== 32'h0000_2000 || cnt_data !== 32'd3) begin
            bad++;
            $display("FAIL zero_len_data: s=%h e=%h c=%h need 00002004 00002000 00000003",
                     start_addr, end_addr, cnt_data);
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        offer(enc(3'b100, 1'b1, 12'h020, 5'd0, 7'b1111011), 32'h0000_6000, 32'd11);
        total++;
        if ({we_start, we_end, we_count} !== 3'b111) begin
            bad++;
            $display("FAIL rst_mid_pre: we=%b need 111", {we_start, we_end, we_count});
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({we_start, we_end, we_count, busy} !== 4'b0000 || inst_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_abort: we/busy=%b ready=%b need 0000 1",
                     {we_start, we_end, we_count, busy}, inst_ready);
        end
        total++;
        if ({regid, start_addr, end_addr, cnt_data} !== 97'd0) begin
            bad++;
            $display("FAIL rst_mid_data: regid=%b s=%h e=%h c=%h need all 0", regid, start_addr, end_addr, cnt_data);
        end
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (inst_ready !== 1'b1 || {we_start, we_end, we_count} !== 3'b000 || end_addr !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_release: ready=%b we=%b e=%h need 1 000 00000000",
                     inst_ready, {we_start, we_end, we_count}, end_addr);
        end
    endtask

    initial begin
        test_reset();
        test_setup();
        test_back_to_back();
        test_counti();
        test_endi_wrap();
        test_illegal();
        test_zero_len();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snitch_hwloop_ctrl.md
SNITCH_HWLOOP_CTRL -- requirements
Module: snitch_hwloop_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: idle cycles after each register write before the next instruction is accepted (legal 0..7).
REQ-002 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port inst_valid_i  input  1  hwloop instruction offered.
REQ-005 SHALL have port inst_ready_o  output  1  instruction accepted when valid&&ready.
REQ-006 SHALL have port inst_data_i  input  32  instruction word.
REQ-007 SHALL have port inst_pc_i  input  32  PC of the instruction.
REQ-008 SHALL have port rs1_data_i  input  32  rs1 operand, valid with inst_valid_i.
REQ-009 SHALL have ports hwloop_regid_o (1), hwloop_start_address_o (32), hwloop_end_address_o (32), hwloop_cnt_data_o (32)  output  loop register set and write data.
REQ-010 SHALL have ports hwloop_we_start_register_o, hwloop_we_end_register_o, hwloop_we_count_register_o  output  1 each  write enables.
REQ-011 SHALL have ports busy_o  output  1  state not IDLE; illegal_o  output  1  one-cycle illegal-instruction pulse.

Function
REQ-012 SHALL decode opcode inst[6:0]=7'b1111011; regid=inst[7]; uimm12=inst[31:20]; uimm5=inst[19:15]; funct3=inst[14:12].
REQ-013 SHALL implement funct3: 000 lp.starti start=pc+(uimm12<<1); 001 lp.endi end=pc+(uimm12<<1); 010 lp.count cnt=rs1; 011 lp.counti cnt=zext(uimm12); 100 lp.setup start=pc+4, end=pc+(uimm12<<1), cnt=rs1; 101 lp.setupi start=pc+4, end=pc+(uimm5<<1), cnt=zext(uimm12).
REQ-014 SHALL compute all addresses as unsigned 32-bit modulo 2^32 (wrap-around, no overflow flag).
REQ-015 SHALL implement FSM IDLE -> WRITE -> SETTLE -> IDLE; WRITE -> IDLE directly when SETTLE_CYCLES=0.
REQ-016 SHALL assert inst_ready_o only in IDLE.
REQ-017 SHALL, on acceptance in cycle t, register regid and data and assert exactly the enables of the decoded instruction for one cycle, t+1 (WRITE).
REQ-018 SHALL hold SETTLE for exactly SETTLE_CYCLES cycles via a down-counter; inst_ready_o returns high at t+2+SETTLE_CYCLES.
REQ-019 SHALL treat a wrong opcode or funct3 110/111 on acceptance as illegal: illegal_o high at t+1, no enables, FSM stays IDLE.
REQ-020 SHALL keep data/regid outputs stable outside WRITE (last written values).
REQ-021 SHALL ignore inst_valid_i while not IDLE; instruction must be held by the producer until accepted.

Reset
REQ-022 SHALL on rst_ni low immediately force IDLE, counter 0, all enables/illegal_o/busy_o 0, regid and data outputs 0; inst_ready_o is 1 after reset.
REQ-023 SHALL abort any WRITE/SETTLE on reset mid-operation with no partial write completing.

Configuration
REQ-024 SHALL, with SNITCH_HWLOOP_CHECK_EN defined, flag lp.setup/lp.endi with uimm12=0 and lp.setupi with uimm5=0 illegal per REQ-019 (zero-length loop).
REQ-025 SHALL, without SNITCH_HWLOOP_CHECK_EN, accept those encodings and write end=pc unchanged.

Structure
REQ-026 SHALL place opcode constant, funct3 enum and state enum in shared package snitch_hwloop_pkg.
REQ-027 SHALL contain one sub-module snitch_hwloop_decode (combinational decode/address compute); FSM and registers stay in top.

Verification
REQ-028 SHALL test lp.setup regid=1, pc=0x1000, uimm12=0x10, rs1=5 -> t+1 start=0x1004, end=0x1020, cnt=5, all three enables, regid=1.
REQ-029 SHALL test back-to-back valid, SETTLE_CYCLES=2 -> second accept exactly 4 cycles after first; ready low 3 cycles.
REQ-030 SHALL test lp.counti uimm12=0xFFF -> only count enable, cnt=0x00000FFF.
REQ-031 SHALL test lp.endi pc=0xFFFFFFF0, uimm12=0x10 -> end=0x00000010 (wrap).
REQ-032 SHALL test funct3=3'b111 -> illegal_o one cycle, no enables, ready stays high; SNITCH_HWLOOP_CHECK_EN build: lp.setupi uimm5=0 -> illegal_o.
REQ-033 SHALL test rst_ni low during WRITE -> enables 0 same cycle, ready=1 after release.
